// File: rtl/isp_hdr_pkg.sv
// rtl/isp_hdr_pkg.sv - shared constants and FSM state type for the HDR tone-curve stage
package isp_hdr_pkg;

    localparam int HDR_BINS        = 256;
    localparam int HDR_RECIP_SHIFT = 24;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2
    } hdr_cg_state_t;

endpackage

// File: rtl/hdr_hist_ram.sv
// rtl/hdr_hist_ram.sv - 256-entry histogram RAM, one write port, one registered read port
module hdr_hist_ram #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         we,
    input  logic [7:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [7:0]   rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem [0:255];

    // Write port; a read at the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, one cycle of latency.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/hdr_curve_gen.sv
// rtl/hdr_curve_gen.sv - luma histogram to 8-bit tone-curve LUT writer (optional bin clip: HDR_CLIP_EN)
module hdr_curve_gen #(
    parameter int          CNT_W    = 21,
    parameter logic [23:0] RECIP    = 24'd10200,
    parameter logic [15:0] CLIP_MAX = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] Pre_YUV,
    input  logic        Pre_YUV_en,
    input  logic        Pre_Frame_vsync,
    output logic        lut_wr_en,
    output logic [7:0]  lut_wr_addr,
    output logic [7:0]  lut_wr_data,
    output logic        lut_done,
    output logic        scan_drop
);
    import isp_hdr_pkg::*;

    localparam int          PROD_W  = CNT_W + HDR_RECIP_SHIFT;
    localparam logic [CNT_W-1:0] BIN_MAX = {CNT_W{1'b1}};

    hdr_cg_state_t    state;
    logic             vsync_d;
    logic [7:0]       clr_cnt;
    logic [8:0]       scan_cnt;
    logic             p1_valid, s1_valid, s2_valid;
    logic [7:0]       p1_addr, s1_addr, s2_addr;
    logic [CNT_W-1:0] cdf;
    logic             wb_valid;
    logic [7:0]       wb_addr;
    logic [CNT_W-1:0] wb_data;

    logic             ram_we;
    logic [7:0]       ram_wa, ram_ra;
    logic [CNT_W-1:0] ram_wd, ram_rd;

    logic             vs_rise, pix_ok, s_issue;
    logic [7:0]       rd_tag;
    logic [CNT_W-1:0] bin_cur, bin_eff, pix_inc, cdf_sum;
    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0] scaled;
    logic [7:0]       lut_val;
    logic             unused_bits;

    assign vs_rise = Pre_Frame_vsync & ~vsync_d;
    assign pix_ok  = Pre_YUV_en && (state == ACCUM);
    assign s_issue = (state == SCAN) && (scan_cnt < 9'(HDR_BINS));
    assign ram_ra  = (state == SCAN) ? scan_cnt[7:0] : Pre_YUV[23:16];

    // Pixel updates and scan reads never overlap, so one tag names the pending read.
    assign rd_tag  = p1_valid ? p1_addr : s1_addr;
    // A read issued on the same edge as a write sees stale data; take the written value instead.
    assign bin_cur = (wb_valid && (wb_addr == rd_tag)) ? wb_data : ram_rd;
    assign pix_inc = (bin_cur == BIN_MAX) ? bin_cur : bin_cur + CNT_W'(1);

`ifdef HDR_CLIP_EN
    assign bin_eff     = (bin_cur > CNT_W'(CLIP_MAX)) ? CNT_W'(CLIP_MAX) : bin_cur;
    assign unused_bits = ^Pre_YUV[15:0];
`else
    assign bin_eff     = bin_cur;
    assign unused_bits = ^{Pre_YUV[15:0], CLIP_MAX};
`endif

    assign cdf_sum = cdf + bin_eff;
    assign prod    = PROD_W'(cdf) * PROD_W'(RECIP);
    assign scaled  = prod[HDR_RECIP_SHIFT +: CNT_W];
    assign lut_val = (|scaled[CNT_W-1:8]) ? 8'hFF : scaled[7:0];

    // Single RAM write port: pixel increment, else scan clear-after-read, else CLEAR sweep.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = 8'd0;
        ram_wd = '0;
        if (p1_valid) begin
            ram_we = 1'b1;
            ram_wa = p1_addr;
            ram_wd = pix_inc;
        end else if (s1_valid) begin
            ram_we = 1'b1;
            ram_wa = s1_addr;
        end else if (state == CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_cnt;
        end
    end

    hdr_hist_ram #(.W(CNT_W)) u_hist (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .rd_addr (ram_ra),
        .rd_data (ram_rd)
    );

    // FSM, accumulate/scan pipelines and LUT write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            vsync_d     <= 1'b0;
            clr_cnt     <= 8'd0;
            scan_cnt    <= 9'd0;
            p1_valid    <= 1'b0;
            p1_addr     <= 8'd0;
            s1_valid    <= 1'b0;
            s1_addr     <= 8'd0;
            s2_valid    <= 1'b0;
            s2_addr     <= 8'd0;
            cdf         <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= 8'd0;
            wb_data     <= '0;
            lut_wr_en   <= 1'b0;
            lut_wr_addr <= 8'd0;
            lut_wr_data <= 8'd0;
            lut_done    <= 1'b0;
            scan_drop   <= 1'b0;
        end else begin
            vsync_d  <= Pre_Frame_vsync;
            p1_valid <= pix_ok;
            p1_addr  <= Pre_YUV[23:16];
            s1_valid <= s_issue;
            s1_addr  <= scan_cnt[7:0];
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            wb_valid <= ram_we;
            wb_addr  <= ram_wa;
            wb_data  <= ram_wd;
            if (s1_valid) begin
                cdf <= cdf_sum;
            end
            lut_wr_en <= s2_valid;
            if (s2_valid) begin
                lut_wr_addr <= s2_addr;
                lut_wr_data <= lut_val;
            end
            lut_done <= lut_wr_en && (lut_wr_addr == 8'hFF);
            if (Pre_YUV_en && (state != ACCUM)) begin
                scan_drop <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'hFF) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (vs_rise) begin
                        state    <= SCAN;
                        scan_cnt <= 9'd0;
                    end
                end
                SCAN: begin
                    if (s_issue) begin
                        scan_cnt <= scan_cnt + 9'd1;
                    end
                    if (lut_done) begin
                        state <= ACCUM;
                        cdf   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_hdr_curve_gen.sv
// tb/tb_hdr_curve_gen.sv - directed self-checking bench for hdr_curve_gen
module tb_hdr_curve_gen;

    localparam logic [23:0] RECIP = 24'hFF0000;
    localparam int          CLIP  = 4;
`ifdef HDR_CLIP_EN
    localparam bit          CLIP_ON = 1'b1;
`else
    localparam bit          CLIP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] Pre_YUV = 24'd0;
    logic        Pre_YUV_en = 1'b0;
    logic        Pre_Frame_vsync = 1'b0;
    logic        lut_wr_en;
    logic [7:0]  lut_wr_addr;
    logic [7:0]  lut_wr_data;
    logic        lut_done;
    logic        scan_drop;

    always #5 clk = ~clk;

    hdr_curve_gen #(
        .CNT_W    (21),
        .RECIP    (RECIP),
        .CLIP_MAX (16'd4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Pre_YUV         (Pre_YUV),
        .Pre_YUV_en      (Pre_YUV_en),
        .Pre_Frame_vsync (Pre_Frame_vsync),
        .lut_wr_en       (lut_wr_en),
        .lut_wr_addr     (lut_wr_addr),
        .lut_wr_data     (lut_wr_data),
        .lut_done        (lut_done),
        .scan_drop       (scan_drop)
    );

    int n_pass = 0;
    int n_total = 0;
    int hist [256];
    int exp_curve [256];
    int cap [256];
    int saved [256];
    int exp_idx = 0;
    int done_seen = 0;
    int stray = 0;
    bit scan_active = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Expected curve straight from the rule: running sum of (clipped) bins, scaled and saturated.
    task automatic build_curve();
        longint cdf, v, b;
        cdf = 0;
        for (int i = 0; i < 256; i++) begin
            b = hist[i];
            if (CLIP_ON && b > CLIP) b = CLIP;
            cdf += b;
            v = (cdf * longint'(RECIP)) >> 24;
            exp_curve[i] = (v > 255) ? 255 : int'(v);
            hist[i] = 0;
        end
    endtask

    task automatic send(input int y);
        @(negedge clk);
        Pre_YUV = {8'(y), 8'h5A, 8'hA5};
        Pre_YUV_en = 1'b1;
        hist[y]++;
    endtask

    task automatic send_ramp();
        for (int y = 0; y < 256; y++) send(y);
    endtask

    task automatic run_frame(input int inject_k);
        int first_k, done_k;
        first_k = -1;
        done_k = -1;
        build_curve();
        exp_idx = 0;
        done_seen = 0;
        scan_active = 1'b1;
        @(negedge clk);
        Pre_YUV_en = 1'b0;
        @(negedge clk);
        Pre_Frame_vsync = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == inject_k) begin
                Pre_YUV = {8'h40, 16'h0};
                Pre_YUV_en = 1'b1;
            end else begin
                Pre_YUV_en = 1'b0;
            end
            if (lut_wr_en && first_k < 0) first_k = k;
            if (lut_done) begin
                done_k = k;
                break;
            end
        end
        Pre_YUV_en = 1'b0;
        Pre_Frame_vsync = 1'b0;
        check("first_write_latency", first_k - 1, 3);
        check("scan_length", done_k, 260);
        repeat (3) @(negedge clk);
        check("write_count", exp_idx, 256);
        check("done_pulses", done_seen, 1);
        scan_active = 1'b0;
    endtask

    // Compare every LUT write against the model curve; addresses must ascend with no gaps.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lut_wr_en) begin
                if (!scan_active) begin
                    stray++;
                end else begin
                    check("wr_addr", lut_wr_addr, exp_idx[7:0]);
                    if (exp_idx < 256) check("wr_data", lut_wr_data, exp_curve[exp_idx]);
                    cap[lut_wr_addr] = lut_wr_data;
                    exp_idx++;
                end
            end
            if (lut_done) begin
                done_seen++;
                check("done_after_last", exp_idx, 256);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit, mism;
        for (int i = 0; i < 256; i++) begin
            hist[i] = 0;
            cap[i] = -1;
        end

        repeat (3) @(negedge clk);
        check("rst_wr_en", lut_wr_en, 0);
        check("rst_wr_addr", lut_wr_addr, 0);
        check("rst_wr_data", lut_wr_data, 0);
        check("rst_done", lut_done, 0);
        check("rst_drop", scan_drop, 0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);

        // Flat frame, all Y=0x80.
        for (int n = 0; n < 256; n++) send(8'h80);
        begin
            int tmp [256];
            tmp = hist;
            build_curve();
            check("model_flat_7f", exp_curve[8'h7F], 0);
            check("model_flat_80", exp_curve[8'h80], CLIP_ON ? 3 : 255);
            hist = tmp;
        end
        run_frame(-1);
        check("flat_ff", cap[8'hFF], CLIP_ON ? 3 : 255);
        check("flat_00", cap[8'h00], 0);

        // Ramp, each code once.
        send_ramp();
        begin
            int tmp [256];
            tmp = hist;
            build_curve();
            check("model_ramp_00", exp_curve[0], 0);
            check("model_ramp_7f", exp_curve[8'h7F], 8'h7F);
            check("model_ramp_ff", exp_curve[8'hFF], 8'hFF);
            hist = tmp;
        end
        run_frame(-1);
        check("ramp_7f", cap[8'h7F], 8'h7F);
        saved = cap;

        // Alternating back-to-back codes exercise write-to-read forwarding.
        for (int n = 0; n < 128; n++) begin
            send(8'h10);
            send(8'h11);
        end
        run_frame(-1);
        check("alt_0f", cap[8'h0F], 0);
        check("alt_10", cap[8'h10], CLIP_ON ? 3 : 8'h7F);
        check("alt_11", cap[8'h11], CLIP_ON ? 7 : 8'hFF);

        // Reset in the middle of a scan.
        send_ramp();
        @(negedge clk);
        Pre_YUV_en = 1'b0;
        build_curve();
        exp_idx = 0;
        scan_active = 1'b1;
        @(negedge clk);
        Pre_Frame_vsync = 1'b1;
        hit = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (lut_wr_en && lut_wr_addr == 8'd100) begin
                hit = 1;
                break;
            end
        end
        check("abort_point_reached", hit, 1);
        #2;
        scan_active = 1'b0;
        stray = 0;
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", lut_wr_en, 0);
        check("abort_wr_addr", lut_wr_addr, 0);
        check("abort_wr_data", lut_wr_data, 0);
        check("abort_done", lut_done, 0);
        Pre_Frame_vsync = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("no_writes_after_abort", stray, 0);
        for (int i = 0; i < 256; i++) cap[i] = -1;
        send_ramp();
        run_frame(-1);
        mism = 0;
        for (int i = 0; i < 256; i++) if (cap[i] != saved[i]) mism++;
        check("reset_repeat_curve", mism, 0);

        // Pixel during scan is dropped and flagged.
        check("drop_clear_before", scan_drop, 0);
        send_ramp();
        run_frame(20);
        check("drop_flag", scan_drop, 1);
        check("drop_curve_40", cap[8'h40], 64);
        send_ramp();
        run_frame(-1);
        check("next_frame_40", cap[8'h40], 64);
        check("drop_sticky", scan_drop, 1);
        check("no_stray_writes", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
